// File: rtl/rv64g_wb_arbiter.sv
// Integer writeback arbiter: round-robin selects one completed result per
// cycle and presents it one cycle later as a write-unlock strobe.

package rv64g_pkg;
   localparam int XLEN     = 64;
   localparam int NUM_REGS = 32;
endpackage

module rv64g_wb_arbiter #(
   parameter  int NUM_SRC = 4,
   localparam int NR      = rv64g_pkg::NUM_REGS,
   localparam int DW      = rv64g_pkg::XLEN,
   localparam int AW      = $clog2(NR)
) (
   input  logic                             clk_i,
   input  logic                             arst_ni,
   input  logic [NUM_SRC-1:0]               src_valid_i,
   input  logic [NUM_SRC-1:0][AW-1:0]       src_rd_addr_i,
   input  logic [NUM_SRC-1:0][DW-1:0]       src_data_i,
   output logic [NUM_SRC-1:0]               src_ready_o,
   output logic                             wr_unlock_en_o,
   output logic [AW-1:0]                    wr_unlock_addr_o,
   output logic [DW-1:0]                    wr_unlock_data_o
);

   localparam int PW = $clog2(NUM_SRC);

   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic          gnt_any;
   logic [PW-1:0] ptr_nxt;

   // Scan ptr, ptr+1, ... (wrapping) and pick the first valid source.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NUM_SRC) j = j - NUM_SRC;
         if (!gnt_any && src_valid_i[j]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(j);
         end
      end
   end

   // One-hot grant back to the sources; all-zero when nothing is valid.
   always_comb begin
      src_ready_o = '0;
      if (gnt_any) src_ready_o[gnt_idx] = 1'b1;
   end

   // Pointer moves just past the winner so it gets lowest priority next.
   always_comb begin
      ptr_nxt = ptr;
      if (gnt_any)
         ptr_nxt = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + PW'(1);
   end

   // Register the winner; x0 results are consumed but never strobe.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         ptr              <= '0;
         wr_unlock_en_o   <= 1'b0;
         wr_unlock_addr_o <= '0;
         wr_unlock_data_o <= '0;
      end else begin
         ptr            <= ptr_nxt;
         wr_unlock_en_o <= 1'b0;
         if (gnt_any) begin
            wr_unlock_en_o   <= |src_rd_addr_i[gnt_idx];
            wr_unlock_addr_o <= src_rd_addr_i[gnt_idx];
            wr_unlock_data_o <= src_data_i[gnt_idx];
         end
      end
   end

endmodule

// File: tb/tb_rv64g_wb_arbiter.sv
// Directed bench for rv64g_wb_arbiter: stimulus pushes expected strobes into
// a queue, a negedge monitor pops and compares them against the outputs.

module tb_rv64g_wb_arbiter;

   localparam int NS = 4;
   localparam int AW = 5;
   localparam int DW = 64;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_t;

   logic                   clk_i = 1'b0;
   logic                   arst_ni;
   logic [NS-1:0]          src_valid_i;
   logic [NS-1:0][AW-1:0]  src_rd_addr_i;
   logic [NS-1:0][DW-1:0]  src_data_i;
   logic [NS-1:0]          src_ready_o;
   logic                   wr_unlock_en_o;
   logic [AW-1:0]          wr_unlock_addr_o;
   logic [DW-1:0]          wr_unlock_data_o;

   wb_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   rv64g_wb_arbiter #(.NUM_SRC(NS)) dut (
      .clk_i            (clk_i),
      .arst_ni          (arst_ni),
      .src_valid_i      (src_valid_i),
      .src_rd_addr_i    (src_rd_addr_i),
      .src_data_i       (src_data_i),
      .src_ready_o      (src_ready_o),
      .wr_unlock_en_o   (wr_unlock_en_o),
      .wr_unlock_addr_o (wr_unlock_addr_o),
      .wr_unlock_data_o (wr_unlock_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Called at posedge+1: drive valids, check grant, then cross one edge.
   // The expected strobe is queued just after the edge so that the monitor
   // must see it on the very next negedge.
   task automatic step(input string name, input logic [NS-1:0] v, input logic [NS-1:0] exp_rdy);
      wb_t e;
      bit  push;
      src_valid_i = v;
      #1;
      check({name, " ready"}, 64'(src_ready_o), 64'(exp_rdy));
      push = 1'b0;
      for (int i = 0; i < NS; i++)
         if (exp_rdy[i] && src_rd_addr_i[i] != '0) begin
            e.addr = src_rd_addr_i[i];
            e.data = src_data_i[i];
            push   = 1'b1;
         end
      @(posedge clk_i);
      #1;
      if (push) exp_q.push_back(e);
   endtask

   // Monitor: every strobe must match the oldest expectation, and every
   // queued expectation must appear on the cycle it is due.
   always @(negedge clk_i) begin
      if (arst_ni === 1'b1) begin
         if (wr_unlock_en_o) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL strobe: unexpected en addr=%0d data=%0h", wr_unlock_addr_o, wr_unlock_data_o);
            end else begin
               wb_t e;
               e = exp_q.pop_front();
               if (wr_unlock_addr_o !== e.addr || wr_unlock_data_o !== e.data) begin
                  bad++;
                  $display("FAIL strobe: got addr=%0d data=%0h expected addr=%0d data=%0h",
                           wr_unlock_addr_o, wr_unlock_data_o, e.addr, e.data);
               end
            end
         end else if (exp_q.size() != 0) begin
            wb_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL strobe: got en=0 expected en=1 addr=%0d data=%0h", e.addr, e.data);
         end
      end
   end

   initial begin
      arst_ni       = 1'b0;
      src_valid_i   = '0;
      src_rd_addr_i = '0;
      src_data_i    = '0;
      #2;
      check("rst en",    64'(wr_unlock_en_o),   64'd0);
      check("rst addr",  64'(wr_unlock_addr_o), 64'd0);
      check("rst data",  wr_unlock_data_o,      64'd0);
      check("rst ready", 64'(src_ready_o),      64'd0);
      @(posedge clk_i);
      #3 arst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // single source
      src_rd_addr_i[2] = 5'd5;
      src_data_i[2]    = 64'hDEAD_BEEF;
      step("single", 4'b0100, 4'b0100);          // ptr -> 3
      step("single idle", 4'b0000, 4'b0000);
      step("single idle2", 4'b0000, 4'b0000);

      // wrap and skip, ptr=3
      src_rd_addr_i[0] = 5'd1;  src_data_i[0] = 64'h100;
      src_rd_addr_i[1] = 5'd2;  src_data_i[1] = 64'h200;
      step("wrap g0", 4'b0011, 4'b0001);         // ptr -> 1
      step("wrap g1", 4'b0010, 4'b0010);         // ptr -> 2
      step("ptr2",    4'b0101, 4'b0100);         // ptr -> 3
      step("ptr3",    4'b1001, 4'b1000);         // ptr -> 0

      // round robin, all valid continuously
      for (int i = 0; i < NS; i++) begin
         src_rd_addr_i[i] = AW'(10 + i);
         src_data_i[i]    = 64'h1111_0000_0000_0000 * (i + 1) + 64'(i);
      end
      step("rr 0", 4'b1111, 4'b0001);
      step("rr 1", 4'b1111, 4'b0010);
      step("rr 2", 4'b1111, 4'b0100);
      step("rr 3", 4'b1111, 4'b1000);
      step("rr 0b", 4'b1111, 4'b0001);          // ptr -> 1

      // x0 result: consumed, no strobe, addr/data still update
      src_rd_addr_i[1] = 5'd0;
      src_data_i[1]    = 64'hABC;
      step("x0", 4'b0010, 4'b0010);              // ptr -> 2
      check("x0 addr", 64'(wr_unlock_addr_o), 64'd0);
      check("x0 data", wr_unlock_data_o,      64'hABC);
      check("x0 en",   64'(wr_unlock_en_o),   64'd0);
      src_rd_addr_i[0] = 5'd3;  src_data_i[0] = 64'h300;
      src_rd_addr_i[2] = 5'd4;  src_data_i[2] = 64'h400;
      step("x0 ptr2", 4'b0101, 4'b0100);         // ptr -> 3
      step("to ptr0", 4'b1000, 4'b1000);         // ptr -> 0

      // same destination from two sources
      src_rd_addr_i[0] = 5'd7;  src_data_i[0] = 64'd1;
      src_rd_addr_i[1] = 5'd7;  src_data_i[1] = 64'd2;
      step("same a", 4'b0011, 4'b0001);
      step("same b", 4'b0010, 4'b0010);          // ptr -> 2

      // reset mid-traffic drops the pending strobe and resets ptr
      src_rd_addr_i[2] = 5'd9;  src_data_i[2] = 64'h999;
      step("pre rst", 4'b0100, 4'b0100);         // ptr -> 3, strobe queued
      arst_ni     = 1'b0;
      src_valid_i = '0;
      #1;
      exp_q.delete();
      check("mid rst en",    64'(wr_unlock_en_o),   64'd0);
      check("mid rst addr",  64'(wr_unlock_addr_o), 64'd0);
      check("mid rst data",  wr_unlock_data_o,      64'd0);
      check("mid rst ready", 64'(src_ready_o),      64'd0);
      #2 arst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      src_rd_addr_i[1] = 5'd6;  src_data_i[1] = 64'h666;
      step("post rst", 4'b1110, 4'b0010);        // lowest valid after reset
      step("tail", 4'b0000, 4'b0000);
      step("tail2", 4'b0000, 4'b0000);

      check("queue drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
